// File: rtl/ram_pkg.sv
// Shared definitions for ram_dp_be_clr: read-during-write modes, clear-engine states, lane merge.
package ram_pkg;

    localparam int unsigned WM_WRITE_FIRST = 0;
    localparam int unsigned WM_READ_FIRST  = 1;
    localparam int unsigned WM_NO_CHANGE   = 2;

    // Widest word lane_merge handles; callers zero-extend into it and truncate the result.
    localparam int unsigned MERGE_MAX_W = 256;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] byteen,
        input int unsigned            lane_w
    );
        logic [MERGE_MAX_W-1:0] word;
        word = old_word;
        for (int unsigned b = 0; b < MERGE_MAX_W; b++) begin
            if (byteen[8'(b / lane_w)]) begin
                word[b] = new_word[b];
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: after reset or a clear request, walks every address writing INIT_VAL while busy.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 11,
    parameter int unsigned          DATA_W   = 16,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = clr_addr;
        case (state)
            ST_CLEAR: begin
                if (clear) begin
                    addr_nxt = '0;
                end else if (clr_addr == '1) begin
                    addr_nxt  = '0;
                    state_nxt = ST_RUN;
                end else begin
                    addr_nxt = clr_addr + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    addr_nxt  = '0;
                    state_nxt = ST_CLEAR;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_data = INIT_VAL;

endmodule

// File: rtl/ram_dp_be_clr.sv
// Simple-dual-port RAM with byte lanes and a built-in clear engine.
// RAM_OUTREG_EN adds a clken-gated output register stage on q_a/q_b.
module ram_dp_be_clr
    import ram_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 11,
    parameter int unsigned        DATA_W   = 16,
    parameter int unsigned        LANE_W   = 8,
    parameter int unsigned        WR_MODE  = 0,
    parameter int unsigned        B_FWD    = 0,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0,
    localparam int unsigned       NL       = DATA_W / LANE_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              clear,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_data,
    input  logic [NL-1:0]     a_byteen,
    input  logic              a_wren,
    output logic [DATA_W-1:0] q_a,
    input  logic [ADDR_W-1:0] b_address,
    output logic [DATA_W-1:0] q_b,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    logic [DATA_W-1:0] old_a;
    logic [DATA_W-1:0] merged_a;
    logic              user_we;
    logic [DATA_W-1:0] qa_r;
    logic [DATA_W-1:0] qb_r;

    ram_clear_fsm #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_VAL (INIT_VAL)
    ) u_clear (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    always_comb begin
        old_a    = mem[a_address];
        merged_a = DATA_W'(lane_merge(MERGE_MAX_W'(old_a), MERGE_MAX_W'(a_data),
                                      MERGE_MAX_W'(a_byteen), LANE_W));
    end

    assign user_we = !busy && clken && a_wren;

    // Clear engine takes priority on the shared write port; user writes are dropped while busy.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= clr_data;
        end else if (user_we) begin
            mem[a_address] <= merged_a;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            qa_r <= '0;
            qb_r <= '0;
        end else if (busy) begin
            qa_r <= '0;
            qb_r <= '0;
        end else if (clken) begin
            if (!a_wren || WR_MODE == WM_READ_FIRST) begin
                qa_r <= old_a;
            end else if (WR_MODE == WM_WRITE_FIRST) begin
                qa_r <= merged_a;
            end
            if (B_FWD != 0 && a_wren && b_address == a_address) begin
                qb_r <= merged_a;
            end else begin
                qb_r <= mem[b_address];
            end
        end
    end

`ifdef RAM_OUTREG_EN
    logic [DATA_W-1:0] qa_o;
    logic [DATA_W-1:0] qb_o;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            qa_o <= '0;
            qb_o <= '0;
        end else if (busy) begin
            qa_o <= '0;
            qb_o <= '0;
        end else if (clken) begin
            qa_o <= qa_r;
            qb_o <= qb_r;
        end
    end

    assign q_a = qa_o;
    assign q_b = qb_o;
`else
    assign q_a = qa_r;
    assign q_b = qb_r;
`endif

endmodule

// File: tb/tb_ram_dp_be_clr.sv
// Bench for ram_dp_be_clr: three instances covering all read-during-write modes and both B_FWD settings.
module tb_ram_dp_be_clr;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int NL    = 2;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] INIT = 16'hA5A5;
`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int MODE [3] = '{0, 1, 2};
    localparam int BFWD [3] = '{0, 1, 0};

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          clken = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] a_address = '0;
    logic [AW-1:0] b_address = '0;
    logic [DW-1:0] a_data = '0;
    logic [NL-1:0] a_byteen = '0;
    logic          a_wren = 1'b0;
    logic [DW-1:0] q_a [3];
    logic [DW-1:0] q_b [3];
    logic          busy [3];

    always #5 clock = ~clock;

    ram_dp_be_clr #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(8), .WR_MODE(0), .B_FWD(0), .INIT_VAL(INIT)) u_wf (
        .clock(clock), .reset_n(reset_n), .clken(clken), .clear(clear),
        .a_address(a_address), .a_data(a_data), .a_byteen(a_byteen), .a_wren(a_wren),
        .q_a(q_a[0]), .b_address(b_address), .q_b(q_b[0]), .busy(busy[0]));
    ram_dp_be_clr #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(8), .WR_MODE(1), .B_FWD(1), .INIT_VAL(INIT)) u_rf (
        .clock(clock), .reset_n(reset_n), .clken(clken), .clear(clear),
        .a_address(a_address), .a_data(a_data), .a_byteen(a_byteen), .a_wren(a_wren),
        .q_a(q_a[1]), .b_address(b_address), .q_b(q_b[1]), .busy(busy[1]));
    ram_dp_be_clr #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(8), .WR_MODE(2), .B_FWD(0), .INIT_VAL(INIT)) u_nc (
        .clock(clock), .reset_n(reset_n), .clken(clken), .clear(clear),
        .a_address(a_address), .a_data(a_data), .a_byteen(a_byteen), .a_wren(a_wren),
        .q_a(q_a[2]), .b_address(b_address), .q_b(q_b[2]), .busy(busy[2]));

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference model: words in an array, fill progress as a plain counter.
    bit            m_busy;
    int            m_ptr;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_qa [3], m_qb [3], m_qa2 [3], m_qb2 [3];

    task automatic model_reset();
        m_busy = 1'b1;
        m_ptr  = 0;
        for (int i = 0; i < 3; i++) begin
            m_qa[i] = '0; m_qb[i] = '0; m_qa2[i] = '0; m_qb2[i] = '0;
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] old_w, new_w;
        logic [DW-1:0] pa [3], pb [3];
        bit was_busy;
        if (!reset_n) return;
        was_busy = m_busy;
        pa = m_qa;
        pb = m_qb;
        if (m_busy) begin
            m_mem[m_ptr] = INIT;
            for (int i = 0; i < 3; i++) begin m_qa[i] = '0; m_qb[i] = '0; end
            if (clear) m_ptr = 0;
            else if (m_ptr == DEPTH - 1) m_busy = 1'b0;
            else m_ptr = m_ptr + 1;
        end else begin
            if (clken) begin
                old_w = m_mem[a_address];
                new_w = old_w;
                if (a_byteen[0]) new_w[7:0]  = a_data[7:0];
                if (a_byteen[1]) new_w[15:8] = a_data[15:8];
                for (int i = 0; i < 3; i++) begin
                    if (!a_wren)       m_qa[i] = old_w;
                    else if (MODE[i] == 0) m_qa[i] = new_w;
                    else if (MODE[i] == 1) m_qa[i] = old_w;
                    m_qb[i] = (a_wren && b_address == a_address && BFWD[i] != 0) ? new_w : m_mem[b_address];
                end
                if (a_wren) m_mem[a_address] = new_w;
            end
            if (clear) begin m_busy = 1'b1; m_ptr = 0; end
        end
        for (int i = 0; i < 3; i++) begin
            if (was_busy) begin m_qa2[i] = '0; m_qb2[i] = '0; end
            else if (clken) begin m_qa2[i] = pa[i]; m_qb2[i] = pb[i]; end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
`ifdef RAM_OUTREG_EN
            check($sformatf("q_a[%0d]", i), 32'(q_a[i]), 32'(m_qa2[i]));
            check($sformatf("q_b[%0d]", i), 32'(q_b[i]), 32'(m_qb2[i]));
`else
            check($sformatf("q_a[%0d]", i), 32'(q_a[i]), 32'(m_qa[i]));
            check($sformatf("q_b[%0d]", i), 32'(q_b[i]), 32'(m_qb[i]));
`endif
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_busy));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic ce, input logic we, input logic [AW-1:0] aa,
                         input logic [DW-1:0] d, input logic [NL-1:0] be, input logic [AW-1:0] ba);
        clken = ce; a_wren = we; a_address = aa; a_data = d; a_byteen = be; b_address = ba; clear = 1'b0;
    endtask

    task automatic count_fill(input string tag);
        int n = 0;
        while (busy[0] && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd16);
    endtask

    task automatic read_a(input logic [AW-1:0] aa);
        drive(1'b1, 1'b0, aa, '0, '0, aa);
        repeat (LAT) tick();
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        check("reset_busy", 32'(busy[0]), 32'd1);
        check("reset_q_a", 32'(q_a[0]), 32'd0);

        reset_n = 1'b1;
        count_fill("init_fill_len");

        for (int a = 0; a < DEPTH; a++) begin
            read_a(AW'(a));
            check("init_read", 32'(q_a[0]), 32'(INIT));
        end

        drive(1'b1, 1'b1, 4'd3, 16'h1234, 2'b01, 4'd0);
        tick();
        read_a(4'd3);
        check("lane_write", 32'(q_a[0]), 32'h0000_A534);
        drive(1'b1, 1'b1, 4'd3, 16'hFFFF, 2'b00, 4'd0);
        tick();
        read_a(4'd3);
        check("byteen_zero", 32'(q_a[0]), 32'h0000_A534);

        drive(1'b1, 1'b1, 4'd5, 16'h0001, 2'b11, 4'd0);
        tick();
        read_a(4'd0);
        drive(1'b1, 1'b1, 4'd5, 16'hBEEF, 2'b11, 4'd0);
        tick();
`ifdef RAM_OUTREG_EN
        drive(1'b1, 1'b0, 4'd0, '0, '0, 4'd0);
        tick();
`endif
        check("rdw_write_first", 32'(q_a[0]), 32'h0000_BEEF);
        check("rdw_read_first", 32'(q_a[1]), 32'h0000_0001);
        check("rdw_no_change", 32'(q_a[2]), 32'h0000_A5A5);

        drive(1'b1, 1'b1, 4'd7, 16'h1111, 2'b11, 4'd0);
        tick();
        drive(1'b1, 1'b1, 4'd7, 16'h5555, 2'b11, 4'd7);
        tick();
`ifdef RAM_OUTREG_EN
        drive(1'b1, 1'b0, 4'd0, '0, '0, 4'd0);
        tick();
`endif
        check("coll_no_fwd", 32'(q_b[0]), 32'h0000_1111);
        check("coll_fwd", 32'(q_b[1]), 32'h0000_5555);

        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, AW'(k + 2), 16'hDEAD, 2'b11, AW'(k));
            tick();
        end
        read_a(4'd3);
        check("clken_off_mem", 32'(q_a[0]), 32'h0000_A534);

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 7) != 0, 1'($urandom), AW'($urandom), DW'($urandom),
                  NL'($urandom), AW'($urandom));
            clear = ($urandom_range(0, 99) == 0);
            tick();
        end
        drive(1'b1, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 40 && busy[0]; k++) tick();

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_busy_rise", 32'(busy[0]), 32'd1);
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        count_fill("refill_restart_len");

        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 40 && m_ptr != 9; k++) tick();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_busy", 32'(busy[0]), 32'd1);
        check("async_q_a", 32'(q_a[1]), 32'd0);
        check("async_q_b", 32'(q_b[1]), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        count_fill("post_reset_fill_len");
        read_a(4'd9);
        check("post_reset_read", 32'(q_a[0]), 32'(INIT));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_dp_be_clr.md
Name: ram_dp_be_clr

Overview:
- Single-clock simple-dual-port block RAM: port A read/write with byte-lane enables, port B read-only.
- Generalised in address/data/lane width, with selectable port-A read-during-write mode and optional A-to-B collision forwarding.
- Built-in clear engine fills the array with INIT_VAL after reset or on request.
- Serves as video/sprite/work RAM in arcade cores where power-on contents must be deterministic.

Parameters:
- ADDR_W, 11, address width; depth = 2**ADDR_W words.
- DATA_W, 16, word width; must be a multiple of LANE_W.
- LANE_W, 8, bits per byte-enable lane; NL = DATA_W/LANE_W lanes.
- WR_MODE, 0, port-A read-during-write: 0 write-first (q_a = merged new word), 1 read-first (q_a = old word), 2 no-change (q_a holds).
- B_FWD, 0, 1 = port B returns the merged new word when reading the address port A writes in the same cycle; 0 = returns the old word.
- INIT_VAL, 0, DATA_W-bit fill value written by the clear engine.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clken  in  1  clock enable for both user ports; the clear engine ignores it.
- clear  in  1  single-cycle request to restart the fill.
- a_address  in  ADDR_W  port-A address.
- a_data  in  DATA_W  port-A write data.
- a_byteen  in  NL  lane write enables; lane i covers bits [i*LANE_W +: LANE_W].
- a_wren  in  1  port-A write strobe.
- q_a  out  DATA_W  port-A read data.
- b_address  in  ADDR_W  port-B address.
- q_b  out  DATA_W  port-B read data.
- busy  out  1  high while the clear engine owns the array.

Behaviour:
- Reset (async assert): state=CLEAR, clr_addr=0, busy=1, q_a=0, q_b=0. The array itself is not reset.
- State CLEAR, each cycle:
  - Write INIT_VAL to all lanes of clr_addr, then increment clr_addr.
  - After writing address 2**ADDR_W-1, next state is RUN and busy falls on that same edge.
  - Fill takes exactly 2**ADDR_W cycles after reset_n rises.
- In CLEAR: user writes are dropped; q_a and q_b are registered as 0 regardless of clken.
- clear=1 in RUN: next state is CLEAR with clr_addr=0 and busy=1. A user write in that same cycle still completes.
- clear=1 in CLEAR: clr_addr restarts at 0.
- RUN with clken=0: no writes; q_a and q_b hold.
- RUN with clken=1 and a_wren=1: lanes with a_byteen[i]=1 take a_data lane i; other lanes keep their old value. a_byteen=0 means no change.
- q_a in RUN:
  - a_wren=0: q_a = mem[a_address] at the next edge.
  - a_wren=1: per WR_MODE.
- q_b in RUN: q_b = mem[b_address] at the next edge. On a collision (a_wren=1 and b_address=a_address), the value follows B_FWD.
- Read latency: 1 cycle after the edge sampling the address (2 with the optional feature).
- Wrap-around: none; each address is an independent word. Out-of-range cannot occur because widths are exact.

Optional Feature:
- Macro: RAM_OUTREG_EN.
- Defined: an extra output register stage on q_a and q_b.
  - Latency becomes 2; the stage advances only when clken=1.
  - It is reset to 0 and forced to 0 while busy.
  - busy is unchanged.
- Undefined: latency 1; no extra flops.

Decomposition:
- Package ram_pkg holds:
  - WR_MODE constants: WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2.
  - The state encoding: ST_CLEAR, ST_RUN.
  - A lane-merge function: (old, new, byteen) -> word.
- One sub-module: ram_clear_fsm. It owns the state, clr_addr and busy, and outputs the clear write address, data and enable that are muxed onto port A. The top level holds the array, write mux and read registers.

Test Plan:
- Reset with ADDR_W=4, INIT_VAL=16'hA5A5, release reset_n -> busy=1 for exactly 16 cycles, then 0; reads of addresses 0..15 return 16'hA5A5.
- Lane write: write 16'h1234 to address 3 with byteen=2'b01 over contents A5A5 -> read returns 16'hA534; byteen=2'b00 -> unchanged.
- WR_MODE 0/1/2: write 16'hBEEF to address 5 holding 16'h0001 with byteen=2'b11 -> q_a next cycle is BEEF / 0001 / previous q_a respectively.
- Collision: A writes 16'h5555 to address 7 (old 16'h1111) while B reads address 7 -> q_b=16'h1111 with B_FWD=0, 16'h5555 with B_FWD=1.
- clken=0 with a_wren=1 and changing addresses -> memory unchanged, q_a and q_b hold. clear pulse in RUN -> busy rises next edge and a 16-cycle refill follows. clear pulsed again mid-fill -> count restarts from 0.
- reset_n asserted mid-fill at clr_addr=9 -> q_a=q_b=0 and busy=1 immediately; after release a full 16-cycle fill follows. With RAM_OUTREG_EN defined, read latency measures 2 cycles.
